// File: rtl/guess_pkg.sv
// Constants and state encoding shared by the guess-number switch decoder and LED encoder.
package guess_pkg;

  localparam int unsigned NUM_LEDS = 10;
  localparam logic [3:0] MAX_DIGIT = 4'd9;
  localparam logic [NUM_LEDS-1:0] ERR_PATTERN = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLINK
  } led_state_e;

endpackage

// File: rtl/digit_to_onehot.sv
// Maps a decimal digit onto its one-hot LED; inverse of the switch decoder.
module digit_to_onehot
  import guess_pkg::*;
(
  input  logic [3:0]          num,
  output logic [NUM_LEDS-1:0] onehot,
  output logic                valid
);

  always_comb begin
    valid  = (num <= MAX_DIGIT);
    onehot = '0;
    if (valid) begin
      onehot = {{(NUM_LEDS-1){1'b0}}, 1'b1} << num;
    end
  end

endmodule

// File: rtl/number_led_encoder.sv
// Shows a loaded digit one-hot on LEDR for a hold time, or blinks all LEDs when out of range.
module number_led_encoder
  import guess_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned BLINK_CYCLES  = 12500000,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                abort,
  input  logic [3:0]          num,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [NUM_LEDS-1:0] LEDR
);

  localparam int unsigned CntMax = (HOLD_CYCLES > BLINK_CYCLES) ? HOLD_CYCLES : BLINK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned TogW   = $clog2(BLINK_TOGGLES + 1);

  localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] BlinkLoad = CntW'(BLINK_CYCLES - 1);
  localparam logic [TogW-1:0] TogLast   = TogW'(BLINK_TOGGLES - 1);

  led_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TogW-1:0]     tog_q, tog_d;
  logic [NUM_LEDS-1:0] ledr_q, ledr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [NUM_LEDS-1:0] digit_onehot;
  logic                digit_valid;

  digit_to_onehot u_digit_to_onehot (
    .num    (num),
    .onehot (digit_onehot),
    .valid  (digit_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    ledr_d  = ledr_q;
    error_d = error_q;
    done_d  = 1'b0;

    if (abort) begin
      // Abort wins over load and never reports completion.
      state_d = IDLE;
      ledr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            if (digit_valid) begin
              ledr_d  = digit_onehot;
              error_d = 1'b0;
              cnt_d   = HoldLoad;
              state_d = SHOW;
            end else begin
              ledr_d  = ERR_PATTERN;
              error_d = 1'b1;
              cnt_d   = BlinkLoad;
              tog_d   = '0;
              state_d = BLINK;
            end
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            ledr_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        BLINK: begin
          if (cnt_q == '0) begin
            if (tog_q == TogLast) begin
              ledr_d  = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ledr_d = ~ledr_q;
              tog_d  = tog_q + 1'b1;
              cnt_d  = BlinkLoad;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          ledr_d  = '0;
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      ledr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      ledr_q  <= ledr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign LEDR  = ledr_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule
